// File: rtl/rr_arbiter_mux.sv
// N-channel WIDTH-bit multiplexor with built-in round-robin or fixed-priority
// selection and a one-entry registered valid/ready output stage.
module rr_arbiter_mux #(
  parameter int WIDTH       = 8,
  parameter int N           = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int SEL_W       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned NU = N;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;

  logic [SEL_W-1:0] w_gnt;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_found;
  logic             w_space;
  logic             w_load;
  int unsigned      w_dist;
  int unsigned      w_best_dist;

  // Winner is the valid channel closest to ptr going upward (mod N); in
  // fixed-priority mode the distance is simply the channel index.
  always_comb begin
    w_found     = 1'b0;
    w_gnt       = '0;
    w_gnt_data  = '0;
    w_best_dist = NU;
    w_dist      = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (ROUND_ROBIN != 0) begin
        w_dist = (i + NU - 32'(r_ptr)) % NU;
      end else begin
        w_dist = i;
      end
      if (in_valid[i] && (w_dist < w_best_dist)) begin
        w_found     = 1'b1;
        w_best_dist = w_dist;
        w_gnt       = SEL_W'(i);
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_space = (r_state == S_EMPTY) || out_ready;
  assign w_load  = w_space && w_found;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      in_ready[i] = rst_n && w_load && (w_gnt == SEL_W'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_load) w_state_nxt = S_FULL;
      S_FULL:  if (out_ready && !w_load) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sel  <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_data <= w_gnt_data;
      r_sel  <= w_gnt;
      if (ROUND_ROBIN != 0) begin
        r_ptr <= (w_gnt == SEL_W'(NU - 1)) ? '0 : w_gnt + SEL_W'(1);
      end
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == S_FULL);

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed bench for rr_arbiter_mux: one round-robin and one fixed-priority
// instance (N=4, WIDTH=8) sharing the same stimulus.
module tb_rr_arbiter_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rr_in_ready, fp_in_ready;
  logic [7:0]  rr_out_data, fp_out_data;
  logic [1:0]  rr_out_sel, fp_out_sel;
  logic        rr_out_valid, fp_out_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter_mux #(.WIDTH(8), .N(4), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  rr_arbiter_mux #(.WIDTH(8), .N(4), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_valid(fp_out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0]  v;
    logic        r;
    logic [31:0] d;
    logic [3:0]  ir;
    logic        ov;
    logic [1:0]  sel;
    logic [7:0]  od;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] BASE = 32'hD3C2B1A0;

    // ptr starts at 0; each row's expectation is the state after that edge
    tbl[0]  = '{4'b1111, 1'b1, BASE,         4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[1]  = '{4'b1111, 1'b1, BASE,         4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[2]  = '{4'b1111, 1'b1, BASE,         4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[3]  = '{4'b1111, 1'b1, BASE,         4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[4]  = '{4'b1111, 1'b1, BASE,         4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[5]  = '{4'b1111, 1'b1, BASE,         4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[6]  = '{4'b1111, 1'b0, BASE,         4'b0000, 1'b1, 2'd1, 8'hB1};
    tbl[7]  = '{4'b1111, 1'b0, BASE,         4'b0000, 1'b1, 2'd1, 8'hB1};
    tbl[8]  = '{4'b1111, 1'b0, BASE,         4'b0000, 1'b1, 2'd1, 8'hB1};
    tbl[9]  = '{4'b1111, 1'b1, BASE,         4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[10] = '{4'b0010, 1'b1, BASE,         4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[11] = '{4'b0011, 1'b1, BASE,         4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[12] = '{4'b0010, 1'b1, BASE,         4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[13] = '{4'b0000, 1'b1, BASE,         4'b0000, 1'b0, 2'd1, 8'hB1};
    tbl[14] = '{4'b0000, 1'b0, BASE,         4'b0000, 1'b0, 2'd1, 8'hB1};
    tbl[15] = '{4'b1000, 1'b0, 32'h5AC2B1A0, 4'b1000, 1'b1, 2'd3, 8'h5A};
    tbl[16] = '{4'b0001, 1'b0, BASE,         4'b0000, 1'b1, 2'd3, 8'h5A};
    tbl[17] = '{4'b0000, 1'b1, BASE,         4'b0000, 1'b0, 2'd3, 8'h5A};

    // Reset with all inputs active
    in_data   = BASE;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst rr out_valid", 32'(rr_out_valid), 32'd0);
    chk("rst rr out_data",  32'(rr_out_data),  32'h0);
    chk("rst rr out_sel",   32'(rr_out_sel),   32'd0);
    chk("rst rr in_ready",  32'(rr_in_ready),  32'h0);
    chk("rst fp out_valid", 32'(fp_out_valid), 32'd0);
    chk("rst fp in_ready",  32'(fp_in_ready),  32'h0);

    @(negedge clk);
    in_valid = 4'b0000;
    rst_n    = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].v;
      out_ready = tbl[i].r;
      in_data   = tbl[i].d;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(rr_in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(rr_out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d out_sel", i),   32'(rr_out_sel),   32'(tbl[i].sel));
      chk($sformatf("vec%0d out_data", i),  32'(rr_out_data),  32'(tbl[i].od));
    end

    // Reset while FULL with ptr=1: must clear asynchronously and restart at ptr 0
    @(negedge clk);
    in_data   = BASE;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst load valid", 32'(rr_out_valid), 32'd1);
    chk("midrst load sel",   32'(rr_out_sel),   32'd0);
    @(negedge clk);
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(rr_out_valid), 32'd0);
    chk("midrst out_data",  32'(rr_out_data),  32'h0);
    chk("midrst out_sel",   32'(rr_out_sel),   32'd0);
    chk("midrst in_ready",  32'(rr_in_ready),  32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post-rst in_ready", 32'(rr_in_ready), 32'b0001);
    @(posedge clk);
    #1;
    chk("post-rst out_valid", 32'(rr_out_valid), 32'd1);
    chk("post-rst out_sel",   32'(rr_out_sel),   32'd0);
    chk("post-rst out_data",  32'(rr_out_data),  32'hA0);

    // Fixed priority: channel 1 always beats channel 3
    @(negedge clk);
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fp%0d in_ready", k), 32'(fp_in_ready), 32'b0010);
      @(posedge clk);
      #1;
      chk($sformatf("fp%0d out_valid", k), 32'(fp_out_valid), 32'd1);
      chk($sformatf("fp%0d out_sel", k),   32'(fp_out_sel),   32'd1);
      chk($sformatf("fp%0d out_data", k),  32'(fp_out_data),  32'hB1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
